sico_rec_arbiter: RTL

SICO_REC_ARBITER -- requirements
Module: sico_rec_arbiter

---
 rtl/sico_rec_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sico_rec_arbiter.sv
// sico_rec_arbiter: round-robin arbiter that funnels NREQ requesters into one
// recorder channel through a single output register with zero-bubble refill.
//
// Ports:
//   clk_i        clock, all logic on rising edge
//   rst_ni       asynchronous active-low reset
//   enable_i     permits new grants when high
//   req_valid_i  per-requester valid
//   req_data_i   per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o  per-requester accept (one-hot or zero, combinational)
//   rec_valid_o  output word valid toward the recorder
//   rec_src_o    index of the requester that produced the word
//   rec_data_o   recorded data
//   rec_seq_o    sequence number of the word
//   rec_ready_i  recorder accepts the word
//   grant_cnt_o  saturating count of words accepted from requesters
module sico_rec_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SRCW  = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rec_valid_o,
  output logic [SRCW-1:0]       rec_src_o,
  output logic [WIDTH-1:0]      rec_data_o,
  output logic [15:0]           rec_seq_o,
  input  logic                  rec_ready_i,
  output logic [31:0]           grant_cnt_o
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q;
  logic [SRCW-1:0]   ptr_q;
  logic [SRCW-1:0]   src_q;
  logic [WIDTH-1:0]  data_q;
  logic [15:0]       rec_seq_q;
  logic [15:0]       seq_q;
  logic [31:0]       grant_cnt_q;

  logic [WIDTH-1:0]  req_data_arr [NREQ];
  logic              found;
  logic [SRCW-1:0]   grant_idx;
  logic [SRCW-1:0]   ptr_next;
  logic              drain;
  logic              can_grant;
  logic              handshake;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data_i[i*WIDTH +: WIDTH];
  end

  // The register may refill in the same cycle it drains, so a full register
  // being consumed is as good as empty for granting purposes.
  assign drain     = (state_q == StFull) && rec_ready_i;
  assign can_grant = enable_i && ((state_q == StEmpty) || rec_ready_i);

  // Round-robin search starting at ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    int unsigned     idx;
    logic [SRCW-1:0] cand;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = idx[SRCW-1:0];
      if (!found && req_valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Reset gates the handshake so req_ready_o is low while rst_ni is asserted.
  assign handshake = found && can_grant && rst_ni;

  always_comb begin
    if (grant_idx == SRCW'(NREQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SRCW'(1);
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      ptr_q       <= '0;
      src_q       <= '0;
      data_q      <= '0;
      rec_seq_q   <= '0;
      seq_q       <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (handshake) begin
        // A new word overrides any simultaneous drain, so the state stays full.
        state_q   <= StFull;
        src_q     <= grant_idx;
        data_q    <= req_data_arr[grant_idx];
        rec_seq_q <= seq_q;
        seq_q     <= seq_q + 16'd1;
        ptr_q     <= ptr_next;
        if (grant_cnt_q != 32'hFFFF_FFFF) begin
          grant_cnt_q <= grant_cnt_q + 32'd1;
        end
      end else if (drain) begin
        state_q <= StEmpty;
      end
    end
  end

  assign rec_valid_o = (state_q == StFull);
  assign rec_src_o   = src_q;
  assign rec_data_o  = data_q;
  assign rec_seq_o   = rec_seq_q;
  assign grant_cnt_o = grant_cnt_q;

endmodule
